profile_window_controller: RTL and testbench

PROFILE_WINDOW_CONTROLLER -- requirements
Module: profile_window_controller

---
 rtl/abacus_pkg.sv | 24 ++
 rtl/abacus_window_timer.sv | 29 ++
 rtl/profile_window_controller.sv | 179 +++++++++++++++++
 tb/tb_profile_window_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/abacus_pkg.sv
// rtl/abacus_pkg.sv - shared window-controller states, register offsets and CTRL bit indices
package abacus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] OFF_CTRL         = 8'h00;
    localparam logic [7:0] OFF_UNIT_MASK    = 8'h04;
    localparam logic [7:0] OFF_WINDOW_LEN   = 8'h08;
    localparam logic [7:0] OFF_STATUS       = 8'h0C;
    localparam logic [7:0] OFF_ELAPSED      = 8'h10;
    localparam logic [7:0] OFF_WINDOW_COUNT = 8'h14;

    localparam int CTRL_START      = 0;
    localparam int CTRL_STOP       = 1;
    localparam int CTRL_IRQ_CLEAR  = 2;
    localparam int CTRL_TRIG_MODE  = 3;
    localparam int CTRL_AUTO_REARM = 4;

endpackage

// File: rtl/abacus_window_timer.sv
// rtl/abacus_window_timer.sv - ELAPSED counter with terminal compare and saturation
module abacus_window_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_run,
    input  logic [31:0] i_window_len,
    output logic [31:0] o_elapsed,
    output logic        o_terminal
);

    logic [31:0] r_elapsed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_elapsed <= 32'd0;
        end else if (i_clear) begin
            r_elapsed <= 32'd0;
        end else if (i_run && (r_elapsed != 32'hFFFF_FFFF)) begin
            r_elapsed <= r_elapsed + 32'd1;
        end
    end

    // A zero length means unbounded, so it never produces a terminal cycle.
    assign o_terminal = i_run && (i_window_len != 32'd0) &&
                        (r_elapsed == (i_window_len - 32'd1));
    assign o_elapsed  = r_elapsed;

endmodule

// File: rtl/profile_window_controller.sv
// rtl/profile_window_controller.sv - Wishbone profiling-window controller; ABACUS_AUTO_REARM_EN adds CTRL auto_rearm
module profile_window_controller
    import abacus_pkg::*;
#(
    parameter logic [31:0] CTRL_BASE_ADDR = 32'hf0030400,
    parameter int          NUM_UNITS      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [31:0]          wb_adr,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack,
    input  logic                 ext_trigger,
    output logic [NUM_UNITS-1:0] unit_enable,
    output logic                 snapshot_pulse,
    output logic                 window_irq
);

    localparam logic [31:0] A_CTRL         = CTRL_BASE_ADDR + 32'(OFF_CTRL);
    localparam logic [31:0] A_UNIT_MASK    = CTRL_BASE_ADDR + 32'(OFF_UNIT_MASK);
    localparam logic [31:0] A_WINDOW_LEN   = CTRL_BASE_ADDR + 32'(OFF_WINDOW_LEN);
    localparam logic [31:0] A_STATUS       = CTRL_BASE_ADDR + 32'(OFF_STATUS);
    localparam logic [31:0] A_ELAPSED      = CTRL_BASE_ADDR + 32'(OFF_ELAPSED);
    localparam logic [31:0] A_WINDOW_COUNT = CTRL_BASE_ADDR + 32'(OFF_WINDOW_COUNT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ack;
    logic [NUM_UNITS-1:0]  r_unit_mask;
    logic [31:0]           r_window_len;
    logic                  r_trig_mode;
    logic                  r_irq;
    logic                  r_snap;
    logic [31:0]           r_window_count;

    logic                  w_req;
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_cfg_ok;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_irq_clr;
    logic                  w_trig_eff;
    logic                  w_auto;
    logic                  w_close;
    logic                  w_timer_clear;
    logic                  w_terminal;
    logic [31:0]           w_elapsed;
    logic [31:0]           w_rdata;

    assign w_req     = wb_cyc & wb_stb;
    assign w_wr      = w_req & wb_we & ~r_ack;
    assign w_wr_ctrl = w_wr && (wb_adr == A_CTRL);
    assign w_cfg_ok  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start   = w_wr_ctrl & wb_dat_i[CTRL_START];
    assign w_stop    = w_wr_ctrl & wb_dat_i[CTRL_STOP];
    assign w_irq_clr = w_wr_ctrl & wb_dat_i[CTRL_IRQ_CLEAR];
    // A start written together with trig_mode uses the newly written mode.
    assign w_trig_eff = (w_wr_ctrl && w_cfg_ok) ? wb_dat_i[CTRL_TRIG_MODE] : r_trig_mode;

`ifdef ABACUS_AUTO_REARM_EN
    logic r_auto_rearm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_auto_rearm <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_auto_rearm <= wb_dat_i[CTRL_AUTO_REARM];
        end
    end

    assign w_auto = r_auto_rearm;
`else
    assign w_auto = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_close     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start && !w_stop) begin
                    w_state_nxt = w_trig_eff ? ST_ARMED : ST_RUNNING;
                end
            end
            ST_ARMED: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (ext_trigger) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (w_stop || w_terminal) begin
                    w_state_nxt = ST_DONE;
                    w_close     = 1'b1;
                end
            end
            ST_DONE: begin
                if ((w_start && !w_stop) || w_auto) begin
                    w_state_nxt = w_trig_eff ? ST_ARMED : ST_RUNNING;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_timer_clear = (w_state_nxt == ST_RUNNING) && (r_state != ST_RUNNING);

    abacus_window_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_timer_clear),
        .i_run        (r_state == ST_RUNNING),
        .i_window_len (r_window_len),
        .o_elapsed    (w_elapsed),
        .o_terminal   (w_terminal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_ack          <= 1'b0;
            r_unit_mask    <= '0;
            r_window_len   <= 32'd0;
            r_trig_mode    <= 1'b0;
            r_irq          <= 1'b0;
            r_snap         <= 1'b0;
            r_window_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_req & ~r_ack;
            r_snap  <= w_close;
            if (w_close) begin
                r_window_count <= r_window_count + 32'd1;
            end
            if (w_close) begin
                r_irq <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq <= 1'b0;
            end
            if (w_wr_ctrl && w_cfg_ok) begin
                r_trig_mode <= wb_dat_i[CTRL_TRIG_MODE];
            end
            if (w_wr && w_cfg_ok && (wb_adr == A_UNIT_MASK)) begin
                r_unit_mask <= wb_dat_i[NUM_UNITS-1:0];
            end
            if (w_wr && w_cfg_ok && (wb_adr == A_WINDOW_LEN)) begin
                r_window_len <= wb_dat_i;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_req) begin
            case (wb_adr)
                A_CTRL:         w_rdata = {27'd0, w_auto, r_trig_mode, 3'b000};
                A_UNIT_MASK:    w_rdata = 32'(r_unit_mask);
                A_WINDOW_LEN:   w_rdata = r_window_len;
                A_STATUS:       w_rdata = {29'd0, r_irq, r_state};
                A_ELAPSED:      w_rdata = w_elapsed;
                A_WINDOW_COUNT: w_rdata = r_window_count;
                default:        w_rdata = 32'd0;
            endcase
        end
    end

    assign wb_dat_o       = w_rdata;
    assign wb_ack         = r_ack;
    assign unit_enable    = (r_state == ST_RUNNING) ? r_unit_mask : '0;
    assign snapshot_pulse = r_snap;
    assign window_irq     = r_irq;

endmodule

// File: tb/tb_profile_window_controller.sv
// tb/tb_profile_window_controller.sv - scoreboard bench for profile_window_controller
module tb_profile_window_controller;

    localparam logic [31:0] BASE = 32'hf0030400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_adr = 32'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        ext_trigger = 1'b0;
    logic [1:0]  unit_enable;
    logic        snapshot_pulse;
    logic        window_irq;

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;
    int run_len = 0;
    logic [1:0] run_val = 2'd0;
    int s;
    int e;
    int t;

    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    int          pulse_q[$];
    int          run_len_q[$];
    logic [1:0]  run_val_q[$];

    profile_window_controller #(
        .CTRL_BASE_ADDR (BASE),
        .NUM_UNITS      (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_cyc         (wb_cyc),
        .wb_stb         (wb_stb),
        .wb_we          (wb_we),
        .wb_adr         (wb_adr),
        .wb_dat_i       (wb_dat_i),
        .wb_dat_o       (wb_dat_o),
        .wb_ack         (wb_ack),
        .ext_trigger    (ext_trigger),
        .unit_enable    (unit_enable),
        .snapshot_pulse (snapshot_pulse),
        .window_irq     (window_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] data, output int edge_idx);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = BASE + 32'(off); wb_dat_i = data;
        @(posedge clk); #1;
        edge_idx = cycle;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input string name, input logic [7:0] off, input logic [31:0] exp);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_adr = BASE + 32'(off);
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic expect_run(input int len, input logic [1:0] val);
        run_len_q.push_back(len);
        run_val_q.push_back(val);
    endtask

    task automatic wait_until(input int target);
        while (cycle < target) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: read data on ack, snapshot pulse timing, and enable run lengths.
    always @(negedge clk) begin
        if (wb_ack && !wb_we) begin
            if (rd_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_read_ack: got %h expected none", wb_dat_o);
            end else begin
                check(rd_name_q.pop_front(), wb_dat_o, rd_q.pop_front());
            end
        end
        if (snapshot_pulse) begin
            if (pulse_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cycle);
            end else begin
                check("pulse_cycle", 32'(cycle), 32'(pulse_q.pop_front()));
            end
        end
        if (unit_enable != 2'd0) begin
            run_len++;
            run_val = unit_enable;
        end else if (run_len != 0) begin
            if (run_len_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_enable_run: got len %0d val %0d expected none", run_len, run_val);
            end else begin
                check("enable_run_len", 32'(run_len), 32'(run_len_q.pop_front()));
                check("enable_run_val", 32'(run_val), 32'(run_val_q.pop_front()));
            end
            run_len = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_unit_enable", 32'(unit_enable), 32'd0);
        check("rst_irq", 32'(window_irq), 32'd0);
        check("rst_pulse", 32'(snapshot_pulse), 32'd0);
        check("rst_ack", 32'(wb_ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wb_read("status_reset", 8'h0C, 32'd0);
        wb_read("count_reset", 8'h14, 32'd0);
        wb_read("len_reset", 8'h08, 32'd0);

        // 5-cycle window with both units enabled
        wb_write(8'h04, 32'd3, e);
        wb_write(8'h08, 32'd5, e);
        wb_read("mask_rb", 8'h04, 32'd3);
        wb_read("len_rb", 8'h08, 32'd5);
        expect_run(5, 2'd3);
        wb_write(8'h00, 32'h1, s);
        pulse_q.push_back(s + 5);
        wait_until(s + 8);
        wb_read("status_done_irq", 8'h0C, 32'd7);
        wb_read("count_1", 8'h14, 32'd1);
        wb_read("elapsed_5", 8'h10, 32'd5);
        wb_write(8'h00, 32'h4, e);
        wb_read("status_irq_clr", 8'h0C, 32'd3);

        // triggered window
        wb_write(8'h00, 32'h8, e);
        wb_read("ctrl_trig_rb", 8'h00, 32'h8);
        wb_write(8'h00, 32'h9, s);
        wb_read("status_armed", 8'h0C, 32'd1);
        wait_until(s + 12);
        check("armed_no_enable", 32'(unit_enable), 32'd0);
        expect_run(5, 2'd3);
        @(negedge clk);
        ext_trigger = 1'b1;
        @(posedge clk); #1;
        t = cycle;
        ext_trigger = 1'b0;
        pulse_q.push_back(t + 5);
        wait_until(t + 8);
        wb_read("count_2", 8'h14, 32'd2);
        wb_read("status_trig_done", 8'h0C, 32'd7);
        wb_write(8'h00, 32'h4, e);
        wb_read("status_clr2", 8'h0C, 32'd3);

        // unbounded window closed by stop after 100 cycles
        wb_write(8'h08, 32'd0, e);
        expect_run(100, 2'd3);
        wb_write(8'h00, 32'h1, s);
        pulse_q.push_back(s + 100);
        wait_until(s + 99);
        wb_write(8'h00, 32'h2, e);
        wb_read("elapsed_100", 8'h10, 32'd100);
        wb_read("status_stop_done", 8'h0C, 32'd7);
        wb_read("count_3", 8'h14, 32'd3);

        // ARMED stop, start+stop priority, config lock while running
        wb_write(8'h00, 32'h4, e);
        wb_write(8'h00, 32'h9, e);
        wb_read("status_armed2", 8'h0C, 32'd1);
        wb_write(8'h00, 32'h2, e);
        wb_read("status_armed_stop", 8'h0C, 32'd0);
        wb_write(8'h00, 32'h3, e);
        wb_read("status_start_stop", 8'h0C, 32'd0);
        wb_read("ctrl_trig_cleared", 8'h00, 32'd0);
        wb_write(8'h08, 32'd6, e);
        expect_run(6, 2'd3);
        wb_write(8'h00, 32'h1, s);
        pulse_q.push_back(s + 6);
        wb_write(8'h08, 32'd99, e);
        wb_read("len_locked", 8'h08, 32'd6);
        wait_until(s + 9);
        wb_read("status_6", 8'h0C, 32'd7);
        wb_read("count_4", 8'h14, 32'd4);
        wb_read("elapsed_6", 8'h10, 32'd6);

        // reset in the middle of an 8-cycle window
        wb_write(8'h08, 32'd8, e);
        expect_run(3, 2'd3);
        wb_write(8'h00, 32'h1, s);
        wait_until(s + 3);
        rst = 1'b1;
        #1;
        check("midrst_enable", 32'(unit_enable), 32'd0);
        check("midrst_irq", 32'(window_irq), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wb_read("post_rst_ctrl", 8'h00, 32'd0);
        wb_read("post_rst_mask", 8'h04, 32'd0);
        wb_read("post_rst_len", 8'h08, 32'd0);
        wb_read("post_rst_status", 8'h0C, 32'd0);
        wb_read("post_rst_elapsed", 8'h10, 32'd0);
        wb_read("post_rst_count", 8'h14, 32'd0);

`ifdef ABACUS_AUTO_REARM_EN
        wb_write(8'h04, 32'd1, e);
        wb_write(8'h08, 32'd4, e);
        wb_write(8'h00, 32'h10, e);
        wb_read("ctrl_auto_rb", 8'h00, 32'h10);
        expect_run(4, 2'd1);
        expect_run(4, 2'd1);
        expect_run(4, 2'd1);
        wb_write(8'h00, 32'h11, s);
        pulse_q.push_back(s + 4);
        pulse_q.push_back(s + 9);
        pulse_q.push_back(s + 14);
        wait_until(s + 10);
        wb_write(8'h00, 32'h0, e);
        wait_until(s + 18);
        wb_read("auto_count_3", 8'h14, 32'd3);
        wb_read("auto_status", 8'h0C, 32'd7);
`else
        wb_write(8'h00, 32'h18, e);
        wb_read("ctrl_no_auto", 8'h00, 32'h8);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("pulse_q_empty", 32'(pulse_q.size()), 32'd0);
        check("run_q_empty", 32'(run_len_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
